cpu_axi_port_arbiter: RTL and testbench
=======================================

// Module: cpu_axi_port_arbiter
// PURPOSE
// Shares one AXI4 master port between the CPU fetch requester and the data requester.
// Runs a single-beat transaction FSM with full VALID/READY tracking and holds each requester until its response returns.
// Sits between the CPU core request/stall interface and the interconnect master slot.
// PARAMETERS
// ID_IF   4'h0   ARID used for fetch reads
// ID_DM   4'h1   ARID/AWID used for data reads/writes
// PORTS
// ACLK            in   1    clock
// ARESET          in   1    synchronous reset, active-high
// if_req          in   1    fetch request, held until if_done
// if_addr         in   32   fetch address
// if_rdata        out  32   fetch data, valid with if_done
// if_done         out  1    1-cycle fetch completion pulse
// dm_read/dm_write in  1/1  data request; mutually exclusive, held until dm_done
// dm_addr/dm_wdata in  32/32 data address / store data
// dm_strb         in   4    store byte strobes
// dm_rdata        out  32   load data, valid with dm_done
// dm_done         out  1    1-cycle data completion pulse
// dm_err          out  1    RRESP/BRESP != OKAY, valid with dm_done
// ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out 4/32/4/3/2/1  read address channel
// ARREADY         in   1
// RID/RDATA/RRESP/RLAST/RVALID  in 4/32/2/1/1;  RREADY  out  1
// AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out 4/32/4/3/2/1  write address channel
// AWREADY         in   1
// WDATA/WSTRB/WLAST/WVALID  out 32/4/1/1;  WREADY  in  1
// BID/BRESP/BVALID  in 4/2/1;  BREADY  out  1
// BEHAVIOUR
// - Fixed: ARLEN=AWLEN=0, ARSIZE=AWSIZE=3'b010, ARBURST=AWBURST=2'b01, WLAST=1.
// - States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. Reset -> IDLE; all VALID/READY, done, err = 0; rdata regs = 0.
// - IDLE: choose requester, register addr/data/strb/ID, go RD_ADDR (fetch or dm_read) or WR_ADDR (dm_write). Min 1 idle cycle between transactions.
// - Arbitration: if only one requester, grant it. If both, grant the one not granted last (round-robin bit; reset value favours data).
// - RD_ADDR: ARVALID=1, ARADDR/ARID stable; on ARVALID&ARREADY -> RD_DATA.
// - RD_DATA: RREADY=1; on RVALID&RLAST&RID==granted ID: latch RDATA into if_rdata or dm_rdata, pulse done 1 cycle, dm_err=(RRESP!=0) for data, -> IDLE.
// - RVALID with mismatched RID: accept (RREADY=1) and discard.
// - WR_ADDR: AWVALID and WVALID both raised on entry; each drops independently after its own handshake, in either order or the same cycle; -> WR_RESP when both done.
// - WR_RESP: BREADY=1; on BVALID&BID==ID_DM: pulse dm_done, dm_err=(BRESP!=0), -> IDLE.
// - VALID never drops before READY. Payload never changes while VALID is high.
// - Requester deasserting mid-transaction: the transaction still completes; done still pulses.
// - Latency, zero-wait slave: read = 3 cycles from grant to done pulse; write = 3 cycles.
// - if_rdata/dm_rdata hold their values until the next completion of the same requester.
// - ARESET mid-transaction: go to IDLE next edge and drop all VALIDs; no done pulse.
// TESTING
// - Fetch only, addr 0x100, slave ARREADY=1, RDATA=0x00000013 -> one AR with ARID=0, if_done pulse, if_rdata=0x13.
// - Fetch and dm_read both held continuously -> grants alternate D,F,D,F; neither requester is starved.
// - dm_write addr 0x2000_0004, data 0xDEADBEEF, strb 4'b0011; WREADY 3 cycles before AWREADY -> one W beat and one AW; dm_done only after BVALID.
// - ARREADY held low 5 cycles -> ARVALID/ARADDR stable throughout; no done pulse until the R handshake.
// - RRESP=2'b10 on dm_read -> dm_done with dm_err=1; a following OKAY read -> dm_err=0.
// - ARESET asserted while in WR_RESP -> next cycle state IDLE, all VALIDs 0, no dm_done pulse.

Source files
------------

// File: rtl/cpu_axi_port_arbiter.sv
// cpu_axi_port_arbiter: shares one AXI4 master port between the fetch and data
// requesters. It runs single-beat transactions, one at a time, and arbitrates
// round-robin when both requesters are waiting.
`timescale 1ns/1ps
module cpu_axi_port_arbiter #(
  parameter logic [3:0] ID_IF = 4'h0,
  parameter logic [3:0] ID_DM = 4'h1
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  // data requester
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_strb,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  // read address channel
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  // read data channel
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  // write address channel
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  // write data channel
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  // write response channel
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                gnt_dm_q, gnt_dm_d;   // current owner is the data requester
  logic                last_dm_q, last_dm_d; // round-robin: last grant went to data
  logic                arvalid_q, arvalid_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                rready_q, rready_d;
  logic                bready_q, bready_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic                dm_err_q, dm_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                dm_any;
  logic                pick_dm;

  // Next-state, arbitration and channel handshake tracking
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    id_d       = id_q;
    gnt_dm_d   = gnt_dm_q;
    last_dm_d  = last_dm_q;
    arvalid_d  = arvalid_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    rready_d   = rready_q;
    bready_d   = bready_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    dm_err_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    dm_any     = dm_read | dm_write;
    pick_dm    = dm_any & (~if_req | ~last_dm_q);

    case (state_q)
      ST_IDLE: begin
        // The done cycle is dead: the finished requester still holds its request.
        if (!if_done_q && !dm_done_q && (if_req || dm_any)) begin
          gnt_dm_d  = pick_dm;
          last_dm_d = pick_dm;
          if (pick_dm) begin
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            strb_d  = dm_strb;
            id_d    = ID_DM;
            if (dm_write) begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = ST_WR_ADDR;
            end else begin
              arvalid_d = 1'b1;
              state_d   = ST_RD_ADDR;
            end
          end else begin
            addr_d    = if_addr;
            id_d      = ID_IF;
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        // Beats with a foreign RID are accepted and dropped.
        if (RVALID && RLAST && (RID == id_q)) begin
          rready_d = 1'b0;
          state_d  = ST_IDLE;
          if (gnt_dm_q) begin
            dm_rdata_d = RDATA;
            dm_done_d  = 1'b1;
            dm_err_d   = (RRESP != 2'b00);
          end else begin
            if_rdata_d = RDATA;
            if_done_d  = 1'b1;
          end
        end
      end
      ST_WR_ADDR: begin
        awvalid_d = awvalid_q & ~AWREADY;
        wvalid_d  = wvalid_q & ~WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (BVALID && (BID == ID_DM)) begin
          bready_d  = 1'b0;
          dm_done_d = 1'b1;
          dm_err_d  = (BRESP != 2'b00);
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      id_q       <= '0;
      gnt_dm_q   <= 1'b0;
      last_dm_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      rready_q   <= 1'b0;
      bready_q   <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      dm_err_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      id_q       <= id_d;
      gnt_dm_q   <= gnt_dm_d;
      last_dm_q  <= last_dm_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      rready_q   <= rready_d;
      bready_q   <= bready_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      dm_err_q   <= dm_err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_done  = if_done_q;
  assign dm_rdata = dm_rdata_q;
  assign dm_done  = dm_done_q;
  assign dm_err   = dm_err_q;

  assign ARID    = id_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'h0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'h0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = awvalid_q;

  assign WDATA   = wdata_q;
  assign WSTRB   = strb_q;
  assign WLAST   = 1'b1;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

endmodule

// File: tb/tb_cpu_axi_port_arbiter.sv
// Bench for cpu_axi_port_arbiter: table of single transactions against a
// configurable AXI slave model, a completion scoreboard, and hand-written
// arbitration and reset sequences.
`timescale 1ns/1ps
module tb_cpu_axi_port_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        if_req, dm_read, dm_write;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_strb;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_done, dm_done, dm_err;
  logic [3:0]  ARID, AWID, ARLEN, AWLEN;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, AWVALID, WVALID, WLAST, RREADY, BREADY;
  logic [3:0]  WSTRB;
  logic        ARREADY, AWREADY, WREADY, RVALID, RLAST, BVALID;
  logic [3:0]  RID, BID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP, BRESP;

  cpu_axi_port_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_strb(dm_strb), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected completions
  typedef struct packed {
    logic        is_dm;
    logic        is_wr;
    logic [31:0] rdata;
    logic        err;
  } sb_t;
  sb_t sb_q[$];

  // Slave configuration, written by the main sequence
  int          slv_ar_stall = 0, slv_aw_dly = 0, slv_w_dly = 0, slv_b_dly = 0;
  logic        slv_rdata_en = 1'b0, slv_bad_rid = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_resp = 2'b00;

  // Slave observations
  int          n_ar = 0, n_aw = 0, n_w = 0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_arid, cap_awid, cap_wstrb;

  // AXI slave model plus VALID/payload stability checks, all on the falling edge
  initial begin
    int ar_cnt, aw_cnt, w_cnt, b_cnt;
    logic rd_pend, rd_bad, aw_got, w_got;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic p_rst, p_arv, p_awv, p_wv, p_rr, p_br;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_arid, p_awid, p_wstrb;
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
    RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; BID = 0; BRESP = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_pend = 0; rd_bad = 0; aw_got = 0; w_got = 0;
    p_rst = 1; p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_br = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_arid = 0; p_awid = 0; p_wstrb = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; rd_bad = 0; aw_got = 0; w_got = 0;
        p_arv = 0; p_awv = 0; p_wv = 0; p_rr = 0; p_br = 0;
      end else begin
        ar_hs = !p_rst && p_arv && ARREADY;
        aw_hs = !p_rst && p_awv && AWREADY;
        w_hs  = !p_rst && p_wv && WREADY;
        r_hs  = !p_rst && RVALID && p_rr;
        b_hs  = !p_rst && BVALID && p_br;
        if (!p_rst && p_arv && !ARREADY) begin
          chk("arvalid_hold", 32'(ARVALID), 32'd1);
          chk("araddr_stable", ARADDR, p_araddr);
          chk("arid_stable", 32'(ARID), 32'(p_arid));
        end
        if (!p_rst && p_awv && !AWREADY) begin
          chk("awvalid_hold", 32'(AWVALID), 32'd1);
          chk("awaddr_stable", AWADDR, p_awaddr);
          chk("awid_stable", 32'(AWID), 32'(p_awid));
        end
        if (!p_rst && p_wv && !WREADY) begin
          chk("wvalid_hold", 32'(WVALID), 32'd1);
          chk("wdata_stable", WDATA, p_wdata);
          chk("wstrb_stable", 32'(WSTRB), 32'(p_wstrb));
        end
        if (ar_hs) begin
          n_ar++; cap_araddr = p_araddr; cap_arid = p_arid;
          rd_pend = 1; rd_bad = slv_bad_rid;
        end
        if (aw_hs) begin n_aw++; cap_awaddr = p_awaddr; cap_awid = p_awid; aw_got = 1; end
        if (w_hs) begin n_w++; cap_wdata = p_wdata; cap_wstrb = p_wstrb; w_got = 1; end
        // read data channel
        if (r_hs) RVALID = 0;
        if (!RVALID && rd_pend) begin
          RLAST = 1; RVALID = 1;
          if (rd_bad) begin
            RID = 4'hF; RDATA = 32'hFFFF_FFFF; RRESP = 2'b00; rd_bad = 0;
          end else begin
            RID = cap_arid; RDATA = slv_rdata_en ? slv_rdata : ~cap_araddr;
            RRESP = slv_resp; rd_pend = 0;
          end
        end
        // address/data readies after the configured wait
        if (ARVALID) begin
          if (ar_cnt >= slv_ar_stall) ARREADY = 1; else begin ARREADY = 0; ar_cnt++; end
        end else begin ARREADY = 0; ar_cnt = 0; end
        if (AWVALID) begin
          if (aw_cnt >= slv_aw_dly) AWREADY = 1; else begin AWREADY = 0; aw_cnt++; end
        end else begin AWREADY = 0; aw_cnt = 0; end
        if (WVALID) begin
          if (w_cnt >= slv_w_dly) WREADY = 1; else begin WREADY = 0; w_cnt++; end
        end else begin WREADY = 0; w_cnt = 0; end
        // write response channel
        if (b_hs) BVALID = 0;
        if (aw_got && w_got && !BVALID) begin
          if (b_cnt >= slv_b_dly) begin
            BVALID = 1; BID = cap_awid; BRESP = slv_resp;
            aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        p_arv = ARVALID; p_awv = AWVALID; p_wv = WVALID; p_rr = RREADY; p_br = BREADY;
        p_araddr = ARADDR; p_arid = ARID; p_awaddr = AWADDR; p_awid = AWID;
        p_wdata = WDATA; p_wstrb = WSTRB;
      end
      p_rst = ARESET;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse
  initial begin
    logic [31:0] last_if, last_dm;
    sb_t e;
    last_if = 0; last_dm = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        last_if = 0; last_dm = 0;
      end else if (if_done || dm_done) begin
        chk("done_exclusive", 32'(if_done & dm_done), 32'd0);
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: if_done=%0b dm_done=%0b, required no completion", if_done, dm_done);
        end else begin
          e = sb_q.pop_front();
          chk("done_requester", 32'(dm_done), 32'(e.is_dm));
          if (e.is_dm) begin
            if (!e.is_wr) last_dm = e.rdata;
            chk("dm_rdata", dm_rdata, last_dm);
            chk("dm_err", 32'(dm_err), 32'(e.err));
            chk("if_rdata_hold", if_rdata, last_if);
          end else begin
            last_if = e.rdata;
            chk("if_rdata", if_rdata, last_if);
            chk("dm_rdata_hold", dm_rdata, last_dm);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion within 50000 cycles");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          kind;        // 0 fetch, 1 data read, 2 data write
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] slv_data;
    logic [1:0]  resp;
    logic        err;
    int          ar_stall, aw_dly, w_dly;
    logic        bad_rid;
    logic        drop_early;  // requester withdraws one cycle after raising
    int          exp_lat;
  } vec_t;

  task automatic do_txn(input vec_t v);
    int lat, ar0, aw0, w0;
    bit got;
    sb_t e;
    @(negedge ACLK);
    slv_ar_stall = v.ar_stall; slv_aw_dly = v.aw_dly; slv_w_dly = v.w_dly; slv_b_dly = 0;
    slv_rdata_en = 1; slv_rdata = v.slv_data; slv_resp = v.resp; slv_bad_rid = v.bad_rid;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w;
    case (v.kind)
      0: begin if_req = 1; if_addr = v.addr; end
      1: begin dm_read = 1; dm_addr = v.addr; end
      default: begin dm_write = 1; dm_addr = v.addr; dm_wdata = v.wdata; dm_strb = v.strb; end
    endcase
    e.is_dm = (v.kind != 0); e.is_wr = (v.kind == 2); e.rdata = v.slv_data; e.err = v.err;
    sb_q.push_back(e);
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(negedge ACLK);
      lat++;
      if (v.drop_early && lat == 1) begin
        if_req = 0; dm_read = 0; dm_write = 0;
        if_addr = 32'hFFFF_FFF0; dm_addr = 32'hFFFF_FFF0; dm_wdata = 0; dm_strb = 0;
      end
      got = (v.kind == 0) ? if_done : dm_done;
    end
    if_req = 0; dm_read = 0; dm_write = 0;
    chk("txn_latency", 32'(lat), 32'(v.exp_lat));
    if (v.kind == 2) begin
      chk("aw_count", 32'(n_aw - aw0), 32'd1);
      chk("w_count", 32'(n_w - w0), 32'd1);
      chk("awaddr", cap_awaddr, v.addr);
      chk("awid", 32'(cap_awid), 32'h1);
      chk("wdata", cap_wdata, v.wdata);
      chk("wstrb", 32'(cap_wstrb), 32'(v.strb));
    end else begin
      chk("ar_count", 32'(n_ar - ar0), 32'd1);
      chk("araddr", cap_araddr, v.addr);
      chk("arid", 32'(cap_arid), (v.kind == 0) ? 32'h0 : 32'h1);
    end
    @(negedge ACLK);
  endtask

  vec_t vecs[10];

  initial begin
    int nf, nd, cnt;
    sb_t e;
    vecs[0] = '{0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0013, 2'b00, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3};
    vecs[1] = '{1, 32'h2000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3};
    vecs[2] = '{2, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00, 1'b0, 0, 3, 0, 1'b0, 1'b0, 6};
    vecs[3] = '{0, 32'h0000_0200, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0, 5, 0, 0, 1'b0, 1'b1, 8};
    vecs[4] = '{1, 32'h2000_0010, 32'h0, 4'h0, 32'hBAD0_BAD0, 2'b10, 1'b1, 0, 0, 0, 1'b0, 1'b0, 3};
    vecs[5] = '{1, 32'h2000_0014, 32'h0, 4'h0, 32'h0000_0001, 2'b00, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3};
    vecs[6] = '{2, 32'h2000_0020, 32'h0102_0304, 4'b1111, 32'h0, 2'b11, 1'b1, 0, 0, 2, 1'b0, 1'b0, 5};
    vecs[7] = '{2, 32'h2000_0024, 32'hA5A5_5A5A, 4'b1000, 32'h0, 2'b00, 1'b0, 0, 2, 2, 1'b0, 1'b1, 5};
    vecs[8] = '{0, 32'h0000_0300, 32'h0, 4'h0, 32'h7777_0001, 2'b00, 1'b0, 0, 0, 0, 1'b1, 1'b0, 4};
    vecs[9] = '{2, 32'h2000_0030, 32'h0BAD_CAFE, 4'b0101, 32'h0, 2'b00, 1'b0, 0, 0, 0, 1'b0, 1'b0, 3};

    ARESET = 1; if_req = 0; dm_read = 0; dm_write = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_strb = 0;
    repeat (3) @(negedge ACLK);
    // reset state and fixed channel attributes
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_wvalid", 32'(WVALID), 32'd0);
    chk("rst_rready", 32'(RREADY), 32'd0);
    chk("rst_bready", 32'(BREADY), 32'd0);
    chk("rst_done", 32'({if_done, dm_done, dm_err}), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("arlen", 32'(ARLEN), 32'd0);
    chk("arsize", 32'(ARSIZE), 32'd2);
    chk("arburst", 32'(ARBURST), 32'd1);
    chk("awlen", 32'(AWLEN), 32'd0);
    chk("awsize", 32'(AWSIZE), 32'd2);
    chk("awburst", 32'(AWBURST), 32'd1);
    chk("wlast", 32'(WLAST), 32'd1);
    ARESET = 0;
    @(negedge ACLK);

    // both requesters held: data wins first after reset, then strict alternation
    slv_ar_stall = 0; slv_rdata_en = 0; slv_resp = 0; slv_bad_rid = 0;
    if_req = 1; if_addr = 32'h0000_1000; dm_read = 1; dm_addr = 32'h0000_3000;
    e = '{1'b1, 1'b0, ~32'h0000_3000, 1'b0}; sb_q.push_back(e);
    e = '{1'b0, 1'b0, ~32'h0000_1000, 1'b0}; sb_q.push_back(e);
    e = '{1'b1, 1'b0, ~32'h0000_3004, 1'b0}; sb_q.push_back(e);
    e = '{1'b0, 1'b0, ~32'h0000_1004, 1'b0}; sb_q.push_back(e);
    nf = 0; nd = 0;
    for (int c = 0; c < 100 && nf < 2; c++) begin
      @(negedge ACLK);
      if (if_done) begin nf++; if_addr = 32'h0000_1004; if (nf == 2) if_req = 0; end
      if (dm_done) begin nd++; dm_addr = 32'h0000_3004; if (nd == 2) dm_read = 0; end
    end
    if_req = 0; dm_read = 0;
    @(negedge ACLK);
    chk("alt_fetch_count", 32'(nf), 32'd2);
    chk("alt_data_count", 32'(nd), 32'd2);
    chk("alt_queue_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);
    chk("table_queue_drained", 32'(sb_q.size()), 32'd0);

    // reset while waiting for the write response
    @(negedge ACLK);
    slv_aw_dly = 0; slv_w_dly = 0; slv_b_dly = 20; slv_resp = 0;
    dm_write = 1; dm_addr = 32'h2000_0040; dm_wdata = 32'h1111_2222; dm_strb = 4'hF;
    cnt = 0;
    while (!BREADY && cnt < 20) begin @(negedge ACLK); cnt++; end
    chk("reach_wr_resp", 32'(BREADY), 32'd1);
    ARESET = 1; dm_write = 0;
    @(negedge ACLK);
    ARESET = 0;
    chk("rst_mid_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_mid_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_mid_wvalid", 32'(WVALID), 32'd0);
    chk("rst_mid_bready", 32'(BREADY), 32'd0);
    chk("rst_mid_dm_done", 32'(dm_done), 32'd0);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge ACLK);
      if (dm_done || if_done) cnt++;
    end
    chk("no_done_after_reset", 32'(cnt), 32'd0);
    chk("rst_mid_dm_rdata", dm_rdata, 32'd0);

    // recovery after reset
    do_txn(vecs[0]);
    chk("final_queue_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
